// File: rtl/i2c_txn_arbiter_if.sv
// rtl/i2c_txn_arbiter_if.sv - requester and I2C-master bundle for the transaction arbiter
// Purpose: groups the requester lanes, the response outputs and both sides of the
//          I2C master handshake so the arbiter takes a single bus port.
// Modports:
//   master : used by i2c_txn_arbiter (drives grant/rsp_*/m_start/m_* command/debug_state)
//   slave  : used by the environment (drives req_*, m_rx_data, m_busy, m_done, m_ack_error)
// Signals:
//   req/req_rw [NUM_REQ], req_addr [7*NUM_REQ], req_wdata [8*NUM_REQ]  requester lanes
//   grant/rsp_valid [NUM_REQ], rsp_rdata [8], rsp_err, rsp_timeout      responses
//   m_start, m_rw_bit, m_slave_addr [7], m_tx_data [8]                  master command
//   m_rx_data [8], m_busy, m_done, m_ack_error                          master status
//   debug_state [3]                                                      FSM encoding
interface i2c_txn_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_rw;
    logic [7*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [7:0]           rsp_rdata;
    logic                 rsp_err;
    logic                 rsp_timeout;
    logic                 m_start;
    logic                 m_rw_bit;
    logic [6:0]           m_slave_addr;
    logic [7:0]           m_tx_data;
    logic [7:0]           m_rx_data;
    logic                 m_busy;
    logic                 m_done;
    logic                 m_ack_error;
    logic [2:0]           debug_state;

    modport master (
        input  req, req_rw, req_addr, req_wdata,
        input  m_rx_data, m_busy, m_done, m_ack_error,
        output grant, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output m_start, m_rw_bit, m_slave_addr, m_tx_data, debug_state
    );

    modport slave (
        output req, req_rw, req_addr, req_wdata,
        output m_rx_data, m_busy, m_done, m_ack_error,
        input  grant, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  m_start, m_rw_bit, m_slave_addr, m_tx_data, debug_state
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin arbiter sharing one I2C master among NUM_REQ requesters
// Purpose: picks a requester round-robin, issues its single-byte transaction to the
//          I2C master, retries NACKs after a gap, enforces a per-attempt timeout and
//          returns a one-cycle response pulse to the owner.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : i2c_txn_arbiter_if.master (requester lanes, responses, master handshake)
module i2c_txn_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int MAX_RETRY      = 2,
    parameter int GAP_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic               clk,
    input  logic               rst_n,
    i2c_txn_arbiter_if.master  bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam int RW = $clog2(MAX_RETRY + 2);

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] G_LAST   = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam logic [RW-1:0] R_MAX    = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ISSUE       = 3'd1,
        WAIT_ACCEPT = 3'd2,
        WAIT_DONE   = 3'd3,
        BACKOFF     = 3'd4,
        RESP        = 3'd5
    } state_t;

    state_t        state;
    logic [IW-1:0] last_winner;
    logic          rw_q;
    logic [TW-1:0] tcnt;
    logic [GW-1:0] gcnt;
    logic [RW-1:0] retry_cnt;
    logic [1:0]    arm;
    logic          early_done;
    logic          early_ack;
    logic [7:0]    early_rx;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          fin;
    logic          fin_ack;
    logic [7:0]    fin_rx;

    function automatic logic [IW-1:0] wrap_idx(input int v);
        return IW'(v % NUM_REQ);
    endfunction

    // Round-robin search starting just after the previous winner.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!pick_valid && bus.req[wrap_idx(int'(last_winner) + i)]) begin
                pick_valid = 1'b1;
                pick_idx   = wrap_idx(int'(last_winner) + i);
            end
        end
    end

    // A done that arrives while m_start is still up is remembered for one cycle
    // so WAIT_ACCEPT can complete on it directly.
    assign fin     = bus.m_done | early_done;
    assign fin_ack = bus.m_done ? bus.m_ack_error : early_ack;
    assign fin_rx  = bus.m_done ? bus.m_rx_data   : early_rx;

    assign bus.debug_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            last_winner      <= LAST_IDX;
            rw_q             <= 1'b0;
            tcnt             <= '0;
            gcnt             <= '0;
            retry_cnt        <= '0;
            arm              <= '0;
            early_done       <= 1'b0;
            early_ack        <= 1'b0;
            early_rx         <= '0;
            bus.grant        <= '0;
            bus.rsp_valid    <= '0;
            bus.rsp_rdata    <= '0;
            bus.rsp_err      <= 1'b0;
            bus.rsp_timeout  <= 1'b0;
            bus.m_start      <= 1'b0;
            bus.m_rw_bit     <= 1'b0;
            bus.m_slave_addr <= '0;
            bus.m_tx_data    <= '0;
        end else begin
            // Two settle cycles after reset before arbitration keeps the first
            // m_start at least two cycles clear of reset release.
            arm           <= {arm[0], 1'b1};
            bus.m_start   <= 1'b0;
            bus.rsp_valid <= '0;
            early_done    <= 1'b0;

            case (state)
                IDLE: begin
                    if (arm[1] && pick_valid) begin
                        rw_q             <= bus.req_rw[pick_idx];
                        bus.m_rw_bit     <= bus.req_rw[pick_idx];
                        bus.m_slave_addr <= bus.req_addr[pick_idx*7 +: 7];
                        bus.m_tx_data    <= bus.req_wdata[pick_idx*8 +: 8];
                        bus.grant        <= NUM_REQ'(1) << pick_idx;
                        last_winner      <= pick_idx;
                        retry_cnt        <= '0;
                        bus.m_start      <= 1'b1;
                        state            <= ISSUE;
                    end
                end

                ISSUE: begin
                    tcnt       <= '0;
                    early_done <= bus.m_done;
                    early_ack  <= bus.m_ack_error;
                    early_rx   <= bus.m_rx_data;
                    state      <= WAIT_ACCEPT;
                end

                WAIT_ACCEPT, WAIT_DONE: begin
                    if (fin) begin
                        if (fin_ack && retry_cnt < R_MAX) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            gcnt      <= '0;
                            state     <= BACKOFF;
                        end else begin
                            bus.rsp_valid   <= bus.grant;
                            bus.rsp_rdata   <= rw_q ? fin_rx : 8'h00;
                            bus.rsp_err     <= fin_ack;
                            bus.rsp_timeout <= 1'b0;
                            state           <= RESP;
                        end
                    end else if (tcnt == T_LAST) begin
                        bus.rsp_valid   <= bus.grant;
                        bus.rsp_rdata   <= 8'h00;
                        bus.rsp_err     <= 1'b1;
                        bus.rsp_timeout <= 1'b1;
                        state           <= RESP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                        if (state == WAIT_ACCEPT && bus.m_busy) begin
                            state <= WAIT_DONE;
                        end
                    end
                end

                BACKOFF: begin
                    if (gcnt == G_LAST) begin
                        bus.m_start <= 1'b1;
                        state       <= ISSUE;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end

                RESP: begin
                    bus.grant <= '0;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
